// File: rtl/controlador_mem_dados_pkg.sv
// pkg_mem_dados: widths, controller state encoding and the queued request
// record shared by the data-memory controller and its request queue.
package pkg_mem_dados;

   localparam int LARG_END  = 8;
   localparam int LARG_DADO = 8;

   // OCIOSO: nothing issued; ACESSO: one memory cycle in flight;
   // RESPOSTA: load data held for the consumer.
   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      ACESSO   = 2'd1,
      RESPOSTA = 2'd2
   } estado_t;

   // One queued load/store, 17 bits: {escrita, endereco, dado}.
   typedef struct packed {
      logic                 escrita;
      logic [LARG_END-1:0]  endereco;
      logic [LARG_DADO-1:0] dado;
   } requisicao_t;

endpackage

// File: rtl/controlador_mem_dados_fila.sv
// fila_requisicoes: in-order request queue for the data-memory controller.
// Depth PROF_FILA (power of two, >= 2); pointers carry one extra wrap bit so
// full and empty are told apart without a counter. Storage is not reset;
// only the pointers are, which empties the queue.
module fila_requisicoes
   import pkg_mem_dados::*;
#(
   parameter int PROF_FILA = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        push_i,
   input  requisicao_t dado_i,
   input  logic        pop_i,
   output requisicao_t dado_o,
   output logic        cheia_o,
   output logic        vazia_o
);

   localparam int             PTR_W = $clog2(PROF_FILA);
   localparam logic [PTR_W:0] UM    = 1;

   requisicao_t    mem_q [PROF_FILA];
   logic [PTR_W:0] wr_ptr_q;
   logic [PTR_W:0] rd_ptr_q;
   logic           faz_push;
   logic           faz_pop;

   assign faz_push = push_i && !cheia_o;
   assign faz_pop  = pop_i && !vazia_o;

   assign vazia_o = (wr_ptr_q == rd_ptr_q);
   assign cheia_o = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign dado_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

   // Read/write pointers; reset empties the queue.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (faz_push) wr_ptr_q <= wr_ptr_q + UM;
         if (faz_pop)  rd_ptr_q <= rd_ptr_q + UM;
      end
   end

   // Entry storage written on accepted push.
   always_ff @(posedge clk_i) begin
      if (faz_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= dado_i;
   end

endmodule

// File: rtl/controlador_mem_dados.sv
// controlador_mem_dados: initiator side of the data-memory bus. Requests are
// queued in order, issued one memory cycle each on EscMem/LerMem, and load
// data is returned through a valid/ready response port.
// Optional macro CTRL_MEM_CONTADORES_EN adds saturating load/store counters.
//
// Handshakes: a transfer happens on a posedge where valid and ready are both
// high; valid, once raised, holds with stable payload until that edge, and
// ready may depend combinationally on the receiver's own state only.
module controlador_mem_dados
   import pkg_mem_dados::*;
#(
   parameter int PROF_FILA = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req_valido,
   output logic                 req_pronto,
   input  logic                 req_escrita,
   input  logic [LARG_END-1:0]  req_endereco,
   input  logic [LARG_DADO-1:0] req_dado,
   output logic                 resp_valido,
   input  logic                 resp_pronto,
   output logic [LARG_DADO-1:0] resp_dado,
   output logic [LARG_END-1:0]  Endereco,
   output logic [LARG_DADO-1:0] DadoEscrito,
   output logic                 EscMem,
   output logic                 LerMem,
   input  logic [LARG_DADO-1:0] DadoLido,
   output logic                 ocupado,
`ifdef CTRL_MEM_CONTADORES_EN
   output logic [15:0]          cont_leituras,
   output logic [15:0]          cont_escritas,
`endif
   output estado_t              estado_dbg
);

   estado_t              estado_q, estado_d;
   logic [LARG_END-1:0]  end_q, end_d;
   logic [LARG_DADO-1:0] dado_esc_q, dado_esc_d;
   logic                 esc_q, esc_d;
   logic                 ler_q, ler_d;
   logic                 resp_valido_q, resp_valido_d;
   logic [LARG_DADO-1:0] resp_dado_q, resp_dado_d;

   requisicao_t          req_in;
   requisicao_t          cabeca;
   logic                 cheia;
   logic                 vazia;
   logic                 push;
   logic                 pop;

   assign req_pronto = !reset && !cheia;
   assign push       = req_valido && req_pronto;
   assign req_in     = {req_escrita, req_endereco, req_dado};

   fila_requisicoes #(
      .PROF_FILA (PROF_FILA)
   ) u_fila (
      .clk_i   (clock),
      .rst_i   (reset),
      .push_i  (push),
      .dado_i  (req_in),
      .pop_i   (pop),
      .dado_o  (cabeca),
      .cheia_o (cheia),
      .vazia_o (vazia)
   );

   // Next state: issue from the queue head, hold load data until taken.
   always_comb begin
      estado_d      = estado_q;
      end_d         = end_q;
      dado_esc_d    = dado_esc_q;
      esc_d         = 1'b0;
      ler_d         = 1'b0;
      resp_valido_d = resp_valido_q;
      resp_dado_d   = resp_dado_q;
      pop           = 1'b0;
      case (estado_q)
         OCIOSO: begin
            if (!vazia) begin
               pop      = 1'b1;
               end_d    = cabeca.endereco;
               estado_d = ACESSO;
               if (cabeca.escrita) begin
                  dado_esc_d = cabeca.dado;
                  esc_d      = 1'b1;
               end else begin
                  ler_d = 1'b1;
               end
            end
         end
         ACESSO: begin
            if (esc_q) begin
               // Store completes at this edge; chain the next op directly.
               if (!vazia) begin
                  pop   = 1'b1;
                  end_d = cabeca.endereco;
                  if (cabeca.escrita) begin
                     dado_esc_d = cabeca.dado;
                     esc_d      = 1'b1;
                  end else begin
                     ler_d = 1'b1;
                  end
               end else begin
                  estado_d = OCIOSO;
               end
            end else begin
               // DadoLido settled on the falling edge of this cycle.
               resp_dado_d   = DadoLido;
               resp_valido_d = 1'b1;
               estado_d      = RESPOSTA;
            end
         end
         RESPOSTA: begin
            if (resp_pronto) begin
               resp_valido_d = 1'b0;
               estado_d      = OCIOSO;
            end
         end
         default: estado_d = OCIOSO;
      endcase
   end

   // State and registered bus/response outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q      <= OCIOSO;
         end_q         <= '0;
         dado_esc_q    <= '0;
         esc_q         <= 1'b0;
         ler_q         <= 1'b0;
         resp_valido_q <= 1'b0;
         resp_dado_q   <= '0;
      end else begin
         estado_q      <= estado_d;
         end_q         <= end_d;
         dado_esc_q    <= dado_esc_d;
         esc_q         <= esc_d;
         ler_q         <= ler_d;
         resp_valido_q <= resp_valido_d;
         resp_dado_q   <= resp_dado_d;
      end
   end

   assign Endereco    = end_q;
   assign DadoEscrito = dado_esc_q;
   assign EscMem      = esc_q;
   assign LerMem      = ler_q;
   assign resp_valido = resp_valido_q;
   assign resp_dado   = resp_dado_q;
   assign ocupado     = !vazia || (estado_q != OCIOSO);
   assign estado_dbg  = estado_q;

`ifdef CTRL_MEM_CONTADORES_EN
   logic [15:0] cont_ler_q;
   logic [15:0] cont_esc_q;

   // Count each op as its ACESSO cycle closes; saturate at all-ones.
   always_ff @(posedge clock) begin
      if (reset) begin
         cont_ler_q <= '0;
         cont_esc_q <= '0;
      end else if (estado_q == ACESSO) begin
         if (ler_q && (cont_ler_q != 16'hFFFF)) cont_ler_q <= cont_ler_q + 16'd1;
         if (esc_q && (cont_esc_q != 16'hFFFF)) cont_esc_q <= cont_esc_q + 16'd1;
      end
   end

   assign cont_leituras = cont_ler_q;
   assign cont_escritas = cont_esc_q;
`endif

endmodule

// File: tb/tb_controlador_mem_dados.sv
// tb_controlador_mem_dados: directed bench with a posedge-write /
// negedge-read memory model attached to the controller's bus.
module tb_controlador_mem_dados;
   import pkg_mem_dados::*;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       req_valido = 1'b0;
   logic       req_pronto;
   logic       req_escrita = 1'b0;
   logic [7:0] req_endereco = '0;
   logic [7:0] req_dado = '0;
   logic       resp_valido;
   logic       resp_pronto = 1'b0;
   logic [7:0] resp_dado;
   logic [7:0] Endereco;
   logic [7:0] DadoEscrito;
   logic       EscMem;
   logic       LerMem;
   logic [7:0] DadoLido = '0;
   logic       ocupado;
   estado_t    estado_dbg;
`ifdef CTRL_MEM_CONTADORES_EN
   logic [15:0] cont_leituras;
   logic [15:0] cont_escritas;
`endif

   int total = 0;
   int bad   = 0;
   int both_hi = 0;

   logic [7:0]  mem [256] = '{default: 8'h00};
   logic [17:0] op_obs[$];
   logic [17:0] exp_q[$];
   logic [7:0]  resp_obs[$];
   logic [7:0]  exp_resp_q[$];

   typedef struct {
      logic       esc;
      logic [7:0] addr;
      logic [7:0] dado;
      logic [7:0] exp_resp;
   } vec_t;

   vec_t tab[8];

   controlador_mem_dados #(.PROF_FILA(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .req_valido   (req_valido),
      .req_pronto   (req_pronto),
      .req_escrita  (req_escrita),
      .req_endereco (req_endereco),
      .req_dado     (req_dado),
      .resp_valido  (resp_valido),
      .resp_pronto  (resp_pronto),
      .resp_dado    (resp_dado),
      .Endereco     (Endereco),
      .DadoEscrito  (DadoEscrito),
      .EscMem       (EscMem),
      .LerMem       (LerMem),
      .DadoLido     (DadoLido),
      .ocupado      (ocupado),
`ifdef CTRL_MEM_CONTADORES_EN
      .cont_leituras(cont_leituras),
      .cont_escritas(cont_escritas),
`endif
      .estado_dbg   (estado_dbg)
   );

   // Clock
   always #5 clock = ~clock;

   // Watchdog
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Memory model: write on rising edge, read on falling edge.
   always @(posedge clock) if (EscMem) mem[Endereco] <= DadoEscrito;
   always @(negedge clock) if (LerMem) DadoLido <= mem[Endereco];

   // Bus and response monitors.
   always @(posedge clock) begin
      if (EscMem && LerMem) both_hi++;
      if (EscMem || LerMem) op_obs.push_back({EscMem, LerMem, Endereco, EscMem ? DadoEscrito : 8'h00});
      if (resp_valido && resp_pronto) resp_obs.push_back(resp_dado);
   end

   task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      total++;
      if (atual !== esperado) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nome, atual, esperado);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One request from an idle controller, timed edge by edge.
   task automatic run_vec(input vec_t v, input int idx);
      req_valido   = 1'b1;
      req_escrita  = v.esc;
      req_endereco = v.addr;
      req_dado     = v.dado;
      resp_pronto  = 1'b1;
      chk($sformatf("v%0d req_pronto", idx), req_pronto, 1);
      tick();  // E0: accepted
      req_valido = 1'b0;
      chk($sformatf("v%0d no_op_e0", idx), {EscMem, LerMem}, 2'b00);
      chk($sformatf("v%0d ocupado_e0", idx), ocupado, 1);
      tick();  // E1: op driven
      chk($sformatf("v%0d op_e1", idx), {EscMem, LerMem}, v.esc ? 2'b10 : 2'b01);
      chk($sformatf("v%0d endereco", idx), Endereco, v.addr);
      if (v.esc) chk($sformatf("v%0d dado_escrito", idx), DadoEscrito, v.dado);
      tick();  // E2
      chk($sformatf("v%0d no_op_e2", idx), {EscMem, LerMem}, 2'b00);
      if (v.esc) begin
         chk($sformatf("v%0d mem", idx), mem[v.addr], v.dado);
         chk($sformatf("v%0d resp_valido_st", idx), resp_valido, 0);
      end else begin
         chk($sformatf("v%0d resp_valido_e2", idx), resp_valido, 1);
         chk($sformatf("v%0d resp_dado", idx), resp_dado, v.exp_resp);
         tick();
         chk($sformatf("v%0d resp_valido_e3", idx), resp_valido, 0);
      end
      chk($sformatf("v%0d ocupado_end", idx), ocupado, 0);
   endtask

   // Present a request and hold it until accepted (bounded).
   task automatic send(input logic esc, input logic [7:0] a, input logic [7:0] d);
      int n = 0;
      req_valido   = 1'b1;
      req_escrita  = esc;
      req_endereco = a;
      req_dado     = d;
      while (!req_pronto && n < 200) begin
         tick();
         n++;
      end
      chk("send req_pronto", req_pronto, 1);
      tick();
      req_valido = 1'b0;
   endtask

   task automatic wait_idle(input string nome);
      int n = 0;
      while (ocupado && n < 200) begin
         tick();
         n++;
      end
      chk(nome, ocupado, 0);
   endtask

   initial begin
      logic [17:0] e;
      logic [17:0] o;
      logic [7:0]  er;
      logic [7:0]  orr;

      tab[0] = '{esc: 1'b1, addr: 8'h10, dado: 8'h2A, exp_resp: 8'h00};
      tab[1] = '{esc: 1'b0, addr: 8'h10, dado: 8'h00, exp_resp: 8'h2A};
      tab[2] = '{esc: 1'b1, addr: 8'hFF, dado: 8'hA5, exp_resp: 8'h00};
      tab[3] = '{esc: 1'b1, addr: 8'h00, dado: 8'h5A, exp_resp: 8'h00};
      tab[4] = '{esc: 1'b0, addr: 8'hFF, dado: 8'h00, exp_resp: 8'hA5};
      tab[5] = '{esc: 1'b0, addr: 8'h00, dado: 8'h00, exp_resp: 8'h5A};
      tab[6] = '{esc: 1'b1, addr: 8'h7F, dado: 8'hC3, exp_resp: 8'h00};
      tab[7] = '{esc: 1'b0, addr: 8'h7F, dado: 8'h00, exp_resp: 8'hC3};

      // Reset state
      repeat (3) tick();
      chk("rst req_pronto", req_pronto, 0);
      chk("rst resp_valido", resp_valido, 0);
      chk("rst resp_dado", resp_dado, 0);
      chk("rst endereco", Endereco, 0);
      chk("rst dado_escrito", DadoEscrito, 0);
      chk("rst escmem_lermem", {EscMem, LerMem}, 2'b00);
      chk("rst ocupado", ocupado, 0);
      chk("rst estado", estado_dbg, OCIOSO);
      reset = 1'b0;
      #1;
      chk("post_rst req_pronto", req_pronto, 1);
      tick();

      // Single requests from idle (store/load round trips, address wrap ends)
      for (int i = 0; i < 8; i++) run_vec(tab[i], i);

      // Back-to-back stores
      op_obs.delete();
      req_valido = 1'b1;
      req_escrita = 1'b1;
      req_endereco = 8'h00; req_dado = 8'h11;
      tick();  // E0
      req_endereco = 8'h01; req_dado = 8'h22;
      chk("b2b no_op_e0", {EscMem, LerMem}, 2'b00);
      tick();  // E1
      req_endereco = 8'h02; req_dado = 8'h33;
      chk("b2b op1", {EscMem, LerMem, Endereco, DadoEscrito}, {2'b10, 8'h00, 8'h11});
      tick();  // E2
      req_valido = 1'b0;
      chk("b2b op2", {EscMem, LerMem, Endereco, DadoEscrito}, {2'b10, 8'h01, 8'h22});
      tick();  // E3
      chk("b2b op3", {EscMem, LerMem, Endereco, DadoEscrito}, {2'b10, 8'h02, 8'h33});
      tick();  // E4
      chk("b2b op_end", {EscMem, LerMem}, 2'b00);
      chk("b2b mem0", mem[0], 8'h11);
      chk("b2b mem1", mem[1], 8'h22);
      chk("b2b mem2", mem[2], 8'h33);
      chk("b2b op_count", op_obs.size(), 3);

      // Stalled response, queue fills, then drains in order
      op_obs.delete();
      resp_obs.delete();
      resp_pronto = 1'b0;
      send(1'b0, 8'h01, 8'h00);
      send(1'b1, 8'h03, 8'h44);
      send(1'b0, 8'h03, 8'h00);
      send(1'b1, 8'h04, 8'h55);
      send(1'b0, 8'h00, 8'h00);
      chk("full req_pronto", req_pronto, 0);
      chk("full resp_valido", resp_valido, 1);
      chk("full resp_dado", resp_dado, 8'h22);
      req_valido = 1'b1; req_escrita = 1'b0; req_endereco = 8'h04; req_dado = 8'h00;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("hold%0d resp", i), {resp_valido, resp_dado}, {1'b1, 8'h22});
         chk($sformatf("hold%0d req_pronto", i), req_pronto, 0);
      end
      resp_pronto = 1'b1;
      send(1'b0, 8'h04, 8'h00);
      wait_idle("drain idle");
      exp_q.push_back({2'b01, 8'h01, 8'h00});
      exp_q.push_back({2'b10, 8'h03, 8'h44});
      exp_q.push_back({2'b01, 8'h03, 8'h00});
      exp_q.push_back({2'b10, 8'h04, 8'h55});
      exp_q.push_back({2'b01, 8'h00, 8'h00});
      exp_q.push_back({2'b01, 8'h04, 8'h00});
      exp_resp_q.push_back(8'h22);
      exp_resp_q.push_back(8'h44);
      exp_resp_q.push_back(8'h11);
      exp_resp_q.push_back(8'h55);
      chk("drain op_count", op_obs.size(), exp_q.size());
      chk("drain resp_count", resp_obs.size(), exp_resp_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (op_obs.size() > 0) ? op_obs.pop_front() : '1;
         chk("drain op", o, e);
      end
      while (exp_resp_q.size() > 0) begin
         er = exp_resp_q.pop_front();
         orr = (resp_obs.size() > 0) ? resp_obs.pop_front() : 8'hXX;
         chk("drain resp", orr, er);
      end

      // Reset during RESPOSTA with queued stores
      resp_pronto = 1'b0;
      send(1'b0, 8'h02, 8'h00);
      send(1'b1, 8'h20, 8'h77);
      send(1'b1, 8'h21, 8'h77);
      send(1'b1, 8'h22, 8'h77);
      chk("pre_rst resp", {resp_valido, resp_dado}, {1'b1, 8'h33});
      chk("pre_rst estado", estado_dbg, RESPOSTA);
      op_obs.delete();
      reset = 1'b1;
      tick();
      chk("mid_rst resp_valido", resp_valido, 0);
      chk("mid_rst escmem_lermem", {EscMem, LerMem}, 2'b00);
      chk("mid_rst ocupado", ocupado, 0);
      chk("mid_rst req_pronto", req_pronto, 0);
      chk("mid_rst estado", estado_dbg, OCIOSO);
      reset = 1'b0;
      #1;
      chk("mid_rst req_pronto_after", req_pronto, 1);
      repeat (6) tick();
      chk("mid_rst no_ops", op_obs.size(), 0);
      chk("mid_rst mem20", mem[8'h20], 8'h00);
      chk("mid_rst no_resp", resp_valido, 0);

`ifdef CTRL_MEM_CONTADORES_EN
      // Counters: cleared by the reset above, then 3 loads and 2 stores
      chk("cnt rst ler", cont_leituras, 0);
      chk("cnt rst esc", cont_escritas, 0);
      run_vec(tab[0], 100);
      run_vec(tab[1], 101);
      run_vec(tab[6], 102);
      run_vec(tab[7], 103);
      run_vec(tab[1], 104);
      chk("cnt leituras", cont_leituras, 3);
      chk("cnt escritas", cont_escritas, 2);
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      chk("cnt clr ler", cont_leituras, 0);
      chk("cnt clr esc", cont_escritas, 0);
`endif

      chk("never both EscMem and LerMem", both_hi, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
